responder_capture: RTL and testbench
====================================

Name: responder_capture

Overview:
Parametrised front end for the quiz-responder: captures N_CH raw contestant buttons, synchronises and debounces each one, and arbitrates the first valid press after the host arms a round. It reports the winner (one-hot and index), flags false starts (presses made before arming), and times out an unanswered round. It sits between the board button pins and the display/scoring logic. It supersedes the plain button-bundling stage with a registered, stateful capture path.

Parameters:
N_CH, 5, number of contestant channels (2..16)
DEB_CYCLES, 4, consecutive stable cycles required to accept a level change (>=1)
TIMEOUT_CYCLES, 100, cycles a round stays armed without a press before timing out; 0 = never time out
IDXW, $clog2(N_CH), winner index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
btn_raw  in  N_CH  asynchronous button levels, bit i = channel i, 1 = pressed
start  in  1  one-cycle pulse: arm a round
clear  in  1  one-cycle pulse: abort/finish round, clear winner and fouls
btn_level  out  N_CH  debounced button levels
armed  out  1  high while in ARMED
locked  out  1  high while in LOCKED
win_valid  out  1  one-cycle pulse on entry to LOCKED
winner_onehot  out  N_CH  winning channel, held while LOCKED, else 0
winner_idx  out  IDXW  index of winning channel, held while LOCKED, else 0
timeout  out  1  one-cycle pulse when an armed round expires
foul  out  N_CH  sticky false-start flags

Behaviour:
- Reset (rst=1 at a clk edge): all sync/debounce flops, counters, and outputs go to 0; FSM goes to IDLE. Reset wins over every other input, including in mid-round or mid-debounce.
- Per channel: 2-FF synchroniser, then debounce. The debounce counter increments while the synced level differs from the stable level. The stable level flips when the count reaches DEB_CYCLES. Any cycle in which synced equals stable resets the counter to 0.
- press_i is a one-cycle internal pulse on the stable-level 0->1 transition. Its latency from the first clk edge sampling the new raw level is DEB_CYCLES+3 cycles. btn_level equals the stable level.
- Release events produce no pulse.
- FSM states and transitions:
  - IDLE: start -> ARMED, load timer with TIMEOUT_CYCLES. Any press_i sets foul[i].
  - ARMED: eligible = press & ~foul.
    - If eligible != 0 -> LOCKED. Winner = lowest-index set bit; win_valid pulses in the first LOCKED cycle.
    - Otherwise, if TIMEOUT_CYCLES != 0, the timer decrements each cycle. On the cycle it reaches 0 (after exactly TIMEOUT_CYCLES armed cycles), the FSM goes to IDLE with timeout=1 for one cycle.
    - A press and timer expiry in the same cycle: the press wins.
    - Fouled channels cannot win.
  - LOCKED: presses are ignored, and no new fouls are raised. The winner is held.
- clear in any state: -> IDLE next cycle, winner outputs 0, foul all 0.
  - clear together with start: clear wins, and the FSM stays in IDLE.
  - clear together with a press in ARMED: clear wins, and there is no win_valid.
- start in ARMED or LOCKED is ignored. The timer does not restart.
- start in IDLE with foul!=0 is allowed; the fouls remain set and masked.
- All outputs are registered.

Decomposition:
- Package responder_pkg holds:
  - state enum {IDLE, ARMED, LOCKED}
  - index-width helper
  - the lowest-set-bit priority function (returns one-hot and index)
- Sub-module responder_debounce: one channel, containing the synchroniser, debounce counter, stable level, and rise pulse. It is instantiated N_CH times via generate.
- FSM, timer, foul register, and winner registers live in the top module.

Test Plan:
- Parameters N_CH=5, DEB_CYCLES=4, TIMEOUT_CYCLES=100 unless stated.
- Reset/bounce:
  - Stimulus: rst 2 cycles.
    - Required response: all outputs 0.
  - Stimulus: btn_raw[2] toggles every 2 cycles for 20 cycles, then holds 1.
    - Required response: btn_level[2] stays 0 through the bounce and rises exactly 7 cycles after the final 0->1 sample.
    - Required response: exactly one internal press.
- Single winner:
  - Stimulus: start, then btn_raw[3]=1.
    - Required response: win_valid pulses once.
    - Required response: winner_onehot=5'b01000, winner_idx=3, locked=1, held until clear.
    - Required response: after clear, everything returns to 0 and armed=locked=0.
- Simultaneous press:
  - Stimulus: armed; btn_raw[4] and btn_raw[1] rise on the same cycle.
    - Required response: winner_idx=1, winner_onehot=5'b00010.
  - Stimulus: btn_raw[0] rises 1 cycle after the lock.
    - Required response: winner unchanged.
- False start:
  - Stimulus: btn_raw[0] pressed in IDLE.
    - Required response: foul=5'b00001.
  - Stimulus: start; press ch0 again; then press ch2.
    - Required response: ch0 is ignored; winner_idx=2; foul still 5'b00001 until clear.
- Timeout/collisions:
  - Stimulus: start, no presses.
    - Required response: timeout pulses exactly 100 cycles after ARMED entry, and the FSM returns to IDLE.
  - Stimulus: TIMEOUT_CYCLES=0.
    - Required response: no timeout after 1000 cycles.
  - Stimulus: start+clear in the same cycle.
    - Required response: the FSM stays in IDLE.
  - Stimulus: rst asserted while LOCKED.
    - Required response: all outputs 0 next cycle.

Source files
------------

// File: rtl/responder_pkg.sv
// Shared types and helpers for the quiz-responder capture path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package responder_pkg;

  // Largest channel count supported by the priority helper.
  localparam int MAX_CH   = 16;
  localparam int MAX_IDXW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Result of the lowest-set-bit pick: one-hot and binary index.
  typedef struct packed {
    logic [MAX_CH-1:0]   onehot;
    logic [MAX_IDXW-1:0] idx;
  } prio_t;

  // Index width for n channels; never below 1 bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lowest-index set bit wins. The loop walks downward so the last hit
  // recorded is the lowest one. Zero input yields zero one-hot and index.
  function automatic prio_t lowest_set(input logic [MAX_CH-1:0] v);
    prio_t r;
    r.onehot = '0;
    r.idx    = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.onehot    = '0;
        r.onehot[i] = 1'b1;
        r.idx       = MAX_IDXW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/responder_debounce.sv
// One button channel: 2-FF synchroniser, debounce counter, stable level, rise pulse.
// Latency: level and rise appear DEB_CYCLES+3 clocks after the first edge sampling a new raw level.
// Backpressure: none; free-running per channel.
module responder_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronise the raw pin, count disagreeing cycles, and flip the stable
  // level once the disagreement has lasted DEB_CYCLES counted cycles. Any
  // agreeing cycle restarts the count, so bounce never accumulates.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES)) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/responder_capture.sv
// Quiz-responder front end: debounce N_CH buttons, arbitrate first eligible press after arming.
// Latency: win_valid one clock after the debounced press pulse; timeout after TIMEOUT_CYCLES armed clocks.
// Backpressure: none; start/clear are single-cycle pulses, clear dominates everything but rst.
module responder_capture
  import responder_pkg::*;
#(
  parameter int N_CH           = 5,
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int IDXW           = idx_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  input  logic            start,
  input  logic            clear,
  output logic [N_CH-1:0] btn_level,
  output logic            armed,
  output logic            locked,
  output logic            win_valid,
  output logic [N_CH-1:0] winner_onehot,
  output logic [IDXW-1:0] winner_idx,
  output logic            timeout,
  output logic [N_CH-1:0] foul
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [N_CH-1:0]   press;
  logic [N_CH-1:0]   eligible;
  logic [MAX_CH-1:0] elig_wide;
  prio_t             pick;
  logic              pick_unused;

  // One debouncer per contestant channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    responder_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .rise (press[g])
    );
  end

  // Fouled channels are masked out; widen to the helper's fixed width.
  always_comb begin
    eligible             = press & ~foul;
    elig_wide            = '0;
    elig_wide[N_CH-1:0]  = eligible;
    pick                 = lowest_set(elig_wide);
  end

  // Upper one-hot/index bits beyond N_CH are structurally zero.
  assign pick_unused = ^pick;

  // Round FSM with timer, foul and winner registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      foul          <= '0;
      winner_onehot <= '0;
      winner_idx    <= '0;
      win_valid     <= 1'b0;
      timeout       <= 1'b0;
      armed         <= 1'b0;
      locked        <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      timeout   <= 1'b0;
      if (clear) begin
        state         <= IDLE;
        timer         <= '0;
        foul          <= '0;
        winner_onehot <= '0;
        winner_idx    <= '0;
        armed         <= 1'b0;
        locked        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            foul <= foul | press;
            if (start) begin
              state <= ARMED;
              armed <= 1'b1;
              timer <= TW'(TIMEOUT_CYCLES);
            end
          end
          ARMED: begin
            // A press beats a timer expiring on the same cycle.
            if (eligible != '0) begin
              state         <= LOCKED;
              armed         <= 1'b0;
              locked        <= 1'b1;
              win_valid     <= 1'b1;
              winner_onehot <= pick.onehot[N_CH-1:0];
              winner_idx    <= pick.idx[IDXW-1:0];
            end else if (TIMEOUT_CYCLES != 0) begin
              if (timer == TW'(1)) begin
                state   <= IDLE;
                armed   <= 1'b0;
                timeout <= 1'b1;
                timer   <= '0;
              end else begin
                timer <= timer - 1'b1;
              end
            end
          end
          LOCKED: begin
            // Winner held; presses and start are ignored until clear.
          end
          default: begin
            state  <= IDLE;
            armed  <= 1'b0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_responder_capture.sv
module tb_responder_capture;

  localparam int N    = 5;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic [N-1:0]    btn_raw = '0;

  logic [N-1:0]    btn_level, winner_onehot, foul;
  logic            armed, locked, win_valid, timeout;
  logic [IDXW-1:0] winner_idx;

  logic [N-1:0]    z_btn_level, z_winner_onehot, z_foul;
  logic            z_armed, z_locked, z_win_valid, z_timeout;
  logic [IDXW-1:0] z_winner_idx;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit is_to;
    int idx;
  } ev_t;
  ev_t sb[$];

  int   lvl2_rises = 0;
  logic lvl2_q = 1'b0;

  responder_capture #(.N_CH(N), .DEB_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .start(start), .clear(clear),
    .btn_level(btn_level), .armed(armed), .locked(locked), .win_valid(win_valid),
    .winner_onehot(winner_onehot), .winner_idx(winner_idx), .timeout(timeout), .foul(foul)
  );

  responder_capture #(.N_CH(N), .DEB_CYCLES(4), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .start(start), .clear(clear),
    .btn_level(z_btn_level), .armed(z_armed), .locked(z_locked), .win_valid(z_win_valid),
    .winner_onehot(z_winner_onehot), .winner_idx(z_winner_idx), .timeout(z_timeout), .foul(z_foul)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},  32'(btn_level), 0);
    check({tag, "_armed"},  32'(armed), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_winv"},   32'(win_valid), 0);
    check({tag, "_woh"},    32'(winner_onehot), 0);
    check({tag, "_widx"},   32'(winner_idx), 0);
    check({tag, "_tmo"},    32'(timeout), 0);
    check({tag, "_foul"},   32'(foul), 0);
  endtask

  // Scoreboard consumer: every win/timeout event must match the next expectation.
  always @(negedge clk) begin
    ev_t e;
    if (win_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_win", 32'(winner_idx), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_kind_win", 0, 32'(e.is_to));
        check("sb_win_idx", 32'(winner_idx), 32'(e.idx));
        check("sb_win_oh", 32'(winner_onehot), 32'(1) << e.idx);
      end
    end
    if (timeout) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_tmo", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_kind_tmo", 1, 32'(e.is_to));
      end
    end
  end

  // Rising edges of debounced channel 2 stand in for its internal press pulse.
  always @(negedge clk) begin
    if (btn_level[2] && !lvl2_q) lvl2_rises++;
    lvl2_q = btn_level[2];
  end

  initial begin
    logic hi;
    logic z_seen;

    // Reset state
    step(2);
    check_all_zero("reset");
    rst = 1'b0;
    step(2);

    // Bounce on channel 2, then a clean hold
    hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_raw[2] = ~btn_raw[2];
      step(1);
      hi |= btn_level[2];
      step(1);
      hi |= btn_level[2];
    end
    check("bounce_level_low", 32'(hi), 0);
    btn_raw[2] = 1'b1;
    step(6);
    check("deb_lat_before", 32'(btn_level[2]), 0);
    step(1);
    check("deb_lat_at7", 32'(btn_level[2]), 1);
    step(3);
    check("bounce_one_press", lvl2_rises, 1);
    check("idle_press_foul", 32'(foul), 32'b00100);
    btn_raw[2] = 1'b0;
    step(10);
    check("release_level", 32'(btn_level[2]), 0);
    check("release_no_press", lvl2_rises, 1);
    pulse_clear();
    check("clear_foul", 32'(foul), 0);

    // Single winner on channel 3
    pulse_start();
    check("arm", 32'(armed), 1);
    sb.push_back('{1'b0, 3});
    btn_raw[3] = 1'b1;
    step(8);
    check("w3_valid", 32'(win_valid), 1);
    check("w3_locked", 32'(locked), 1);
    check("w3_armed", 32'(armed), 0);
    check("w3_oh", 32'(winner_onehot), 32'b01000);
    check("w3_idx", 32'(winner_idx), 3);
    pulse_start();
    check("w3_start_ignored", 32'(locked), 1);
    check("w3_valid_once", 32'(win_valid), 0);
    step(4);
    check("w3_hold_oh", 32'(winner_onehot), 32'b01000);
    check("w3_hold_idx", 32'(winner_idx), 3);
    pulse_clear();
    check("w3_clr_oh", 32'(winner_onehot), 0);
    check("w3_clr_idx", 32'(winner_idx), 0);
    check("w3_clr_locked", 32'(locked), 0);
    check("w3_clr_armed", 32'(armed), 0);
    btn_raw = '0;
    step(12);

    // Simultaneous press on channels 4 and 1
    pulse_start();
    sb.push_back('{1'b0, 1});
    btn_raw[4] = 1'b1;
    btn_raw[1] = 1'b1;
    step(8);
    check("sim_idx", 32'(winner_idx), 1);
    check("sim_oh", 32'(winner_onehot), 32'b00010);
    btn_raw[0] = 1'b1;
    step(10);
    check("late_idx", 32'(winner_idx), 1);
    check("late_oh", 32'(winner_onehot), 32'b00010);
    check("late_no_foul", 32'(foul), 0);
    pulse_clear();
    btn_raw = '0;
    step(12);
    check("rel_no_foul", 32'(foul), 0);

    // False start on channel 0
    btn_raw[0] = 1'b1;
    step(8);
    check("fs_foul", 32'(foul), 32'b00001);
    btn_raw[0] = 1'b0;
    step(10);
    pulse_start();
    btn_raw[0] = 1'b1;
    step(9);
    check("fs_masked_locked", 32'(locked), 0);
    check("fs_masked_armed", 32'(armed), 1);
    sb.push_back('{1'b0, 2});
    btn_raw[2] = 1'b1;
    step(8);
    check("fs_win_idx", 32'(winner_idx), 2);
    check("fs_foul_kept", 32'(foul), 32'b00001);
    pulse_clear();
    check("fs_foul_clr", 32'(foul), 0);
    btn_raw = '0;
    step(12);

    // Timeout after exactly 100 armed cycles; TIMEOUT_CYCLES=0 never expires
    sb.push_back('{1'b1, 0});
    pulse_start();
    step(99);
    check("tmo_armed_99", 32'(armed), 1);
    check("tmo_not_yet", 32'(timeout), 0);
    step(1);
    check("tmo_pulse", 32'(timeout), 1);
    check("tmo_idle", 32'(armed), 0);
    step(1);
    check("tmo_one_cycle", 32'(timeout), 0);
    z_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      z_seen |= z_timeout;
    end
    check("t0_no_timeout", 32'(z_seen), 0);
    check("t0_still_armed", 32'(z_armed), 1);
    pulse_clear();

    // start and clear together
    start = 1'b1;
    clear = 1'b1;
    step(1);
    start = 1'b0;
    clear = 1'b0;
    check("sc_armed", 32'(armed), 0);
    step(1);
    check("sc_armed2", 32'(armed), 0);
    check("sc_locked", 32'(locked), 0);

    // Reset while locked
    sb.push_back('{1'b0, 3});
    pulse_start();
    btn_raw[3] = 1'b1;
    step(8);
    check("rl_locked", 32'(locked), 1);
    rst = 1'b1;
    step(1);
    check_all_zero("rst_locked");
    rst = 1'b0;
    btn_raw = '0;
    step(15);
    check("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
